step_bcd_conv: RTL and testbench
================================

STEP_BCD_CONV -- requirements
Module: step_bcd_conv

Interface
REQ-001 The block SHALL have parameter IN_W, default 14, giving the binary input width; legal range is 14..16.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock (100 MHz); all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to convert bin_in.
REQ-005 The block SHALL have port bin_in, input, IN_W bits: unsigned binary value to convert, e.g. a step count or speed.
REQ-006 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse when new digits become valid.
REQ-008 The block SHALL have port ovf, output, 1 bit: the last accepted value exceeded 9999.
REQ-009 The block SHALL have ports dig0, dig1, dig2, dig3, output, 4 bits each: BCD ones, tens, hundreds and thousands, wired directly to the display driver's in0..in3.

Function
REQ-010 The block SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-011 In IDLE with start=1, the block SHALL capture bin_in into an internal shift register and enter SHIFT on the next edge.
- This is the acceptance cycle, cycle 0.
REQ-012 At capture, if bin_in > 9999, the block SHALL load 9999 instead of bin_in and set an internal ovf flag; otherwise it SHALL clear that flag.
REQ-013 SHIFT SHALL last exactly IN_W cycles, tracked by a counter of ceil(log2(IN_W+1)) bits.
REQ-014 Each SHIFT cycle SHALL perform one double-dabble step:
- add 3 to every 4-bit BCD working nibble whose value is >= 5;
- then shift the combined {BCD, binary} register left by one bit.
REQ-015 After the IN_W-th shift the FSM SHALL enter DONE.
- DONE lasts one cycle (cycle IN_W+1).
- FSM then returns unconditionally to IDLE.
REQ-016 In the DONE cycle, dig0..dig3 and ovf SHALL update together with done=1.
REQ-017 Outside the DONE cycle, dig0..dig3 and ovf SHALL hold their previous values, so the display never shows partial results.
REQ-018 busy SHALL be 1 from cycle 1 through the DONE cycle inclusive, and 0 in IDLE.
REQ-019 Latency SHALL be fixed: done asserts exactly IN_W+1 cycles after the acceptance edge, independent of data.
REQ-020 start SHALL be ignored while busy=1, including in the DONE cycle.
- An in-flight conversion is never restarted or altered.
- A start held continuously produces back-to-back conversions spaced IN_W+2 cycles apart.
REQ-021 bin_in SHALL be sampled only in the acceptance cycle; later changes to bin_in SHALL NOT affect the result.
REQ-022 Every output digit SHALL be in the range 0..9; codes 10..15 SHALL never be driven.
REQ-023 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-024 While rst_n=0 at a clock edge, the block SHALL set state=IDLE, busy=0, done=0, ovf=0, dig0..dig3=0, and clear the shift counter and working registers.
REQ-025 A reset asserted mid-conversion SHALL abort it.
- No done pulse is produced.
- Digits read 0 on the cycle after the reset edge.
REQ-026 A start asserted in the same cycle as rst_n=0 SHALL be ignored.
REQ-027 The first start that can be accepted SHALL be in the first cycle with rst_n=1.

Verification
REQ-028 Case bin_in=0: start for 1 cycle -> busy=1 for 15 cycles, done at cycle 15, digits 0,0,0,0, ovf=0.
REQ-029 Case bin_in=1234: start -> done at cycle 15 with dig3..dig0 = 1,2,3,4 and ovf=0; digits hold 1234 afterwards with start=0.
REQ-030 Boundary case: bin_in=9999 -> 9,9,9,9 with ovf=0; then bin_in=12000 -> 9,9,9,9 with ovf=1; then bin_in=10 -> 0,0,1,0 with ovf cleared.
REQ-031 Case: start with 4321, then change bin_in to 5 and re-pulse start at cycles 3 and 15 -> exactly one done pulse (at cycle 15) showing 4,3,2,1; the second start is ignored.
REQ-032 Case: start held high with bin_in=7 -> done pulses at cycles 15, 31, 47, each showing 0,0,0,7.
REQ-033 Case: 5678 converted, then start with 42 and rst_n=0 at cycle 6 -> no done pulse, digits 0,0,0,0, busy=0; the next start after release converts normally.

Source files
------------

// File: rtl/step_bcd_conv.sv
// step_bcd_conv: sequential binary-to-BCD converter (double dabble, one bit
// per clock) for a 4-digit display. Inputs above 9999 saturate to 9999.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   start        request to convert bin_in (ignored while busy)
//   bin_in       unsigned binary value, IN_W bits
//   busy         high from the cycle after acceptance through the done cycle
//   done         one-cycle pulse when new digits become valid
//   ovf          last accepted value exceeded 9999
//   dig0..dig3   BCD ones, tens, hundreds, thousands
module step_bcd_conv #(
    parameter int unsigned IN_W = 14
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [IN_W-1:0] bin_in,
    output logic            busy,
    output logic            done,
    output logic            ovf,
    output logic [3:0]      dig0,
    output logic [3:0]      dig1,
    output logic [3:0]      dig2,
    output logic [3:0]      dig3
);

    localparam int unsigned CNT_W = $clog2(IN_W + 1);
    localparam int unsigned BCD_W = 16;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [IN_W-1:0]  bin_q, bin_d;
    logic             sat_q, sat_d;
    logic             busy_d, done_d, ovf_d;
    logic [3:0]       dig0_d, dig1_d, dig2_d, dig3_d;

    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_sh;
    logic [IN_W-1:0]  bin_sh;

    // One double-dabble step: correct nibbles >= 5, then shift {bcd, bin} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_sh = {bcd_adj[BCD_W-2:0], bin_q[IN_W-1]};
        bin_sh = {bin_q[IN_W-2:0], 1'b0};
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        sat_d   = sat_q;
        busy_d  = busy;
        done_d  = 1'b0;
        ovf_d   = ovf;
        dig0_d  = dig0;
        dig1_d  = dig1;
        dig2_d  = dig2;
        dig3_d  = dig3;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bcd_d   = '0;
                    busy_d  = 1'b1;
                    if (bin_in > IN_W'(9999)) begin
                        bin_d = IN_W'(9999);
                        sat_d = 1'b1;
                    end else begin
                        bin_d = bin_in;
                        sat_d = 1'b0;
                    end
                end
            end
            SHIFT: begin
                bcd_d = bcd_sh;
                bin_d = bin_sh;
                cnt_d = cnt_q + CNT_W'(1);
                // Last shift: publish digits so they appear with done.
                if (cnt_q == CNT_W'(IN_W - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    ovf_d   = sat_q;
                    dig0_d  = bcd_sh[3:0];
                    dig1_d  = bcd_sh[7:4];
                    dig2_d  = bcd_sh[11:8];
                    dig3_d  = bcd_sh[15:12];
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bcd_q   <= '0;
            bin_q   <= '0;
            sat_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            dig0    <= 4'd0;
            dig1    <= 4'd0;
            dig2    <= 4'd0;
            dig3    <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            sat_q   <= sat_d;
            busy    <= busy_d;
            done    <= done_d;
            ovf     <= ovf_d;
            dig0    <= dig0_d;
            dig1    <= dig1_d;
            dig2    <= dig2_d;
            dig3    <= dig3_d;
        end
    end

endmodule

// File: tb/tb_step_bcd_conv.sv
// tb_step_bcd_conv: directed, table-driven bench for step_bcd_conv.
// Cycle 0 is the acceptance cycle; outputs are sampled on the falling edge.
module tb_step_bcd_conv;

    localparam int unsigned IN_W = 14;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [IN_W-1:0] bin_in;
    logic            busy;
    logic            done;
    logic            ovf;
    logic [3:0]      dig0, dig1, dig2, dig3;

    step_bcd_conv #(.IN_W(IN_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bin_in (bin_in),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf),
        .dig0   (dig0),
        .dig1   (dig1),
        .dig2   (dig2),
        .dig3   (dig3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs [10];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int digits();
        return int'({dig3, dig2, dig1, dig0});
    endfunction

    // Called at a falling edge: present a start request for the coming edge.
    task automatic launch(input int v);
        start  = 1'b1;
        bin_in = IN_W'(v);
    endtask

    // Runs ncyc cycles after acceptance with start low, recording done/busy.
    task automatic watch(input int ncyc, output int first_done,
                         output int n_done, output int busy_cnt);
        first_done = -1;
        n_done     = 0;
        busy_cnt   = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
        end
    endtask

    int fd, nd, bc;
    int done_cyc [3];

    initial begin
        vecs[0] = '{0,     16'h0000, 1'b0};
        vecs[1] = '{1234,  16'h1234, 1'b0};
        vecs[2] = '{9999,  16'h9999, 1'b0};
        vecs[3] = '{12000, 16'h9999, 1'b1};
        vecs[4] = '{10,    16'h0010, 1'b0};
        vecs[5] = '{16383, 16'h9999, 1'b1};
        vecs[6] = '{1,     16'h0001, 1'b0};
        vecs[7] = '{9000,  16'h9000, 1'b0};
        vecs[8] = '{5005,  16'h5005, 1'b0};
        vecs[9] = '{10000, 16'h9999, 1'b1};

        // Reset with start asserted: start must be ignored.
        rst_n  = 1'b0;
        start  = 1'b1;
        bin_in = IN_W'(1234);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ovf", int'(ovf), 0);
        chk("reset_digits", digits(), 0);

        // First vector is launched in the first cycle with rst_n high.
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            launch(vecs[i].bin);
            watch(17, fd, nd, bc);
            chk($sformatf("v%0d_done_cycle", i), fd, 15);
            chk($sformatf("v%0d_done_count", i), nd, 1);
            chk($sformatf("v%0d_busy_cycles", i), bc, 15);
            chk($sformatf("v%0d_digits", i), digits(), int'(vecs[i].bcd));
            chk($sformatf("v%0d_ovf", i), int'(ovf), int'(vecs[i].ovf));
        end

        // Digits hold with start low.
        repeat (5) @(negedge clk);
        chk("hold_digits", digits(), 16'h9999);
        chk("hold_ovf", int'(ovf), 1);
        chk("hold_busy", int'(busy), 0);

        // Start re-pulsed at cycles 3 and 15 with a new bin_in: ignored.
        launch(4321);
        nd = 0;
        fd = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                nd++;
                if (fd < 0) fd = c;
            end
            bin_in = IN_W'(5);
            start  = (c == 3 || c == 15);
        end
        chk("repulse_done_cycle", fd, 15);
        chk("repulse_done_count", nd, 1);
        chk("repulse_digits", digits(), 16'h4321);
        chk("repulse_busy_after", int'(busy), 0);

        // Start held high: back-to-back conversions every 16 cycles.
        launch(7);
        nd = 0;
        for (int c = 1; c <= 47; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                if (nd < 3) done_cyc[nd] = c;
                nd++;
                chk($sformatf("held_digits_%0d", nd), digits(), 16'h0007);
            end
            if (c == 47) start = 1'b0;
        end
        chk("held_done_count", nd, 3);
        if (nd >= 3) begin
            chk("held_done0", done_cyc[0], 15);
            chk("held_done1", done_cyc[1], 31);
            chk("held_done2", done_cyc[2], 47);
        end
        @(negedge clk);
        @(negedge clk);
        chk("held_stop_busy", int'(busy), 0);

        // Reset mid-conversion aborts with no done pulse.
        launch(5678);
        watch(17, fd, nd, bc);
        chk("pre_abort_digits", digits(), 16'h5678);
        launch(42);
        nd = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (done) nd++;
            if (c == 6) rst_n = 1'b0;
            if (c == 7) begin
                rst_n = 1'b1;
                chk("abort_digits", digits(), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_ovf", int'(ovf), 0);
            end
        end
        chk("abort_done_count", nd, 0);
        chk("abort_digits_later", digits(), 0);

        launch(42);
        watch(17, fd, nd, bc);
        chk("after_abort_done_cycle", fd, 15);
        chk("after_abort_digits", digits(), 16'h0042);
        chk("after_abort_ovf", int'(ovf), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
